// File: rtl/sigma_delta_adc_cic3_if.sv
// Bitstream-in / PCM-out bus for the sinc^3 decimator.
// Handshake: valid-only, no ready. The producer offers one bit per clk
// with d_valid=1; the decimator presents q with a one-clk q_valid pulse
// and never stalls, so the consumer must capture q on q_valid. clip is
// meaningful only when q_valid=1.
interface sigma_delta_adc_cic3_if #(
  parameter int signalwidth = 16
);
  logic                          d;
  logic                          d_valid;
  logic signed [signalwidth-1:0] q;
  logic                          q_valid;
  logic                          clip;

  modport master (output d, output d_valid, input q, input q_valid, input clip);
  modport slave  (input d, input d_valid, output q, output q_valid, output clip);
endinterface

// File: rtl/sigma_delta_adc_cic3.sv
// 1-bit sigma-delta/PDM to signed PCM: 3rd-order CIC decimator, R = 2**decim_log2.
// Integrators wrap modulo 2**W; the comb recovers the exact difference as long
// as the true output fits in W bits, which W = 3*decim_log2+2 guarantees.
module sigma_delta_adc_cic3 #(
  parameter int signalwidth = 16,
  parameter int decim_log2  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sigma_delta_adc_cic3_if.slave bus
);
  localparam int W   = 3 * decim_log2 + 2;
  localparam int S   = signalwidth - 1 - 3 * decim_log2;
  localparam int SHL = (S >= 0) ? S : 0;
  localparam int SHR = (S < 0) ? -S : 0;

  localparam logic [decim_log2-1:0] CNT_LAST = '1;
  localparam logic [decim_log2-1:0] CNT_ONE  = decim_log2'(1);
  localparam logic signed [W-1:0]   X_POS    = W'(1);
  localparam logic signed [W-1:0]   X_NEG    = '1;
  localparam logic signed [63:0]    Q_MAX    = (longint'(1) <<< (signalwidth - 1)) - 1;
  localparam logic signed [63:0]    Q_MIN    = -(longint'(1) <<< (signalwidth - 1));

  logic signed [W-1:0]           i1, i2, i3;
  logic signed [W-1:0]           d1, d2, d3;
  logic signed [W-1:0]           x, i1_n, i2_n, i3_n, c1, c2, c3;
  logic [decim_log2-1:0]         cnt;
  logic [1:0]                    warm;
  logic                          frame_done;
  logic                          emit;
  logic signed [63:0]            c3_ext;
  logic signed [63:0]            q_pre;
  logic signed [signalwidth-1:0] q_sat;
  logic                          sat;

  // Integrator cascade, comb and output scaling/saturation for the current bit.
  always_comb begin
    x          = bus.d ? X_POS : X_NEG;
    i1_n       = i1 + x;
    i2_n       = i2 + i1_n;
    i3_n       = i3 + i2_n;
    c1         = i3_n - d1;
    c2         = c1 - d2;
    c3         = c2 - d3;
    frame_done = bus.d_valid && (cnt == CNT_LAST);
    emit       = frame_done && (warm == 2'd2);
    c3_ext     = {{(64 - W){c3[W-1]}}, c3};
    q_pre      = (S >= 0) ? (c3_ext <<< SHL) : (c3_ext >>> SHR);
    q_sat      = q_pre[signalwidth-1:0];
    sat        = 1'b0;
    if (q_pre > Q_MAX) begin
      q_sat = {1'b0, {(signalwidth - 1){1'b1}}};
      sat   = 1'b1;
    end else if (q_pre < Q_MIN) begin
      q_sat = {1'b1, {(signalwidth - 1){1'b0}}};
      sat   = 1'b1;
    end
  end

  // Integrators and frame counter advance only on accepted bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1  <= '0;
      i2  <= '0;
      i3  <= '0;
      cnt <= '0;
    end else if (bus.d_valid) begin
      i1  <= i1_n;
      i2  <= i2_n;
      i3  <= i3_n;
      cnt <= cnt + CNT_ONE;
    end
  end

  // Comb delays and warmup advance once per completed frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1   <= '0;
      d2   <= '0;
      d3   <= '0;
      warm <= 2'd0;
    end else if (frame_done) begin
      d1 <= i3_n;
      d2 <= c1;
      d3 <= c2;
      if (warm != 2'd2) warm <= warm + 2'd1;
    end
  end

  // Registered output: q holds between pulses, valid/clip pulse for one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.q       <= '0;
      bus.q_valid <= 1'b0;
      bus.clip    <= 1'b0;
    end else begin
      bus.q_valid <= emit;
      bus.clip    <= emit && sat;
      if (emit) bus.q <= q_sat;
    end
  end
endmodule
